// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester ids and
// the default ready-timeout.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAR,
        WDATA,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        PORT_FETCH,
        PORT_DATA
    } port_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-requester round-robin picker; remembers which port was served last
// so a tie goes to the other port.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  req_f_i,
    input  logic  req_d_i,
    input  logic  update_i,
    input  port_t served_i,
    output logic  gnt_valid_o,
    output port_t gnt_port_o
);

    port_t last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_DATA;
        end else if (update_i) begin
            last_q <= served_i;
        end
    end

    always_comb begin
        gnt_valid_o = req_f_i | req_d_i;
        gnt_port_o  = PORT_FETCH;
        if (req_f_i && req_d_i) begin
            gnt_port_o = (last_q == PORT_DATA) ? PORT_FETCH : PORT_DATA;
        end else if (req_d_i) begin
            gnt_port_o = PORT_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MAR/MDR memory path between instruction fetch and load/store,
// sequencing memory_control strobes and returning data with a done pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT,
    parameter int unsigned DW          = 16,
    parameter int unsigned AW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic [DW-1:0] mc_from_bus,
    output logic          mc_ld_mar,
    output logic          mc_ld_mdr,
    output logic          mc_mio_en,
    output logic          mc_rw,
    input  logic [DW-1:0] mc_bus_out,
    input  logic          mc_ready,
    output logic          busy,
    output logic          timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

    state_t        state_q;
    port_t         port_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [CW-1:0] cnt_q;
    logic          to_q;
    logic [DW-1:0] f_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic          gnt_valid;
    port_t         gnt_port;
    logic          in_resp;
    logic          take_rdata;
    logic [DW-1:0] rdata_resp;

    rr_arb2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .req_f_i    (f_req),
        .req_d_i    (d_req),
        .update_i   (in_resp),
        .served_i   (port_q),
        .gnt_valid_o(gnt_valid),
        .gnt_port_o (gnt_port)
    );

    assign in_resp    = (state_q == RESP);
    assign take_rdata = in_resp && (!we_q || to_q);
    assign rdata_resp = to_q ? '0 : mc_bus_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            port_q    <= PORT_DATA;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            to_q      <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        port_q  <= gnt_port;
                        we_q    <= (gnt_port == PORT_DATA) && d_we;
                        addr_q  <= (gnt_port == PORT_DATA) ? d_addr : f_addr;
                        wdata_q <= d_wdata;
                        to_q    <= 1'b0;
                        state_q <= MAR;
                    end
                end
                MAR: begin
                    cnt_q   <= '0;
                    state_q <= we_q ? WDATA : ACCESS;
                end
                WDATA: begin
                    cnt_q   <= '0;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (mc_ready) begin
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        to_q    <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (take_rdata) begin
                        if (port_q == PORT_FETCH) f_rdata_q <= rdata_resp;
                        else                      d_rdata_q <= rdata_resp;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data is presented through during RESP so it is valid alongside done.
    always_comb begin
        f_rdata = f_rdata_q;
        d_rdata = d_rdata_q;
        if (take_rdata && port_q == PORT_FETCH) f_rdata = rdata_resp;
        if (take_rdata && port_q == PORT_DATA)  d_rdata = rdata_resp;
    end

    always_comb begin
        mc_from_bus = '0;
        mc_ld_mar   = 1'b0;
        mc_ld_mdr   = 1'b0;
        mc_mio_en   = 1'b0;
        mc_rw       = 1'b0;
        case (state_q)
            MAR: begin
                mc_from_bus = DW'(addr_q);
                mc_ld_mar   = 1'b1;
            end
            WDATA: begin
                mc_from_bus = wdata_q;
                mc_ld_mdr   = 1'b1;
            end
            ACCESS: begin
                mc_mio_en = 1'b1;
                mc_rw     = we_q;
                mc_ld_mdr = !we_q && mc_ready;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign f_done      = in_resp && (port_q == PORT_FETCH);
    assign d_done      = in_resp && (port_q == PORT_DATA);
    assign timeout_err = in_resp && to_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory_control stub, directed vector table,
// tie/reset sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_done, d_done, busy, timeout_err;
    logic [15:0] f_rdata, d_rdata, mc_from_bus, mc_bus_out;
    logic        mc_ld_mar, mc_ld_mdr, mc_mio_en, mc_rw, mc_ready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYC(TO), .DW(16), .AW(16)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mc_from_bus(mc_from_bus), .mc_ld_mar(mc_ld_mar), .mc_ld_mdr(mc_ld_mdr),
        .mc_mio_en(mc_mio_en), .mc_rw(mc_rw), .mc_bus_out(mc_bus_out),
        .mc_ready(mc_ready), .busy(busy), .timeout_err(timeout_err)
    );

    // memory_control stand-in: MAR/MDR plus a sparse memory and a ready delay
    logic [15:0] mar = '0;
    logic [15:0] mdr = '0;
    logic [15:0] mem [logic [15:0]];
    int          acc_cnt = 0;
    int          cur_delay = 0;
    bit          stuck = 1'b0;

    assign mc_bus_out = mdr;
    assign mc_ready   = mc_mio_en && !stuck && (acc_cnt >= cur_delay);

    always @(posedge clk) begin
        if (mc_ld_mar) mar <= mc_from_bus;
        if (mc_ld_mdr) mdr <= mc_mio_en ? (mem.exists(mar) ? mem[mar] : 16'h0) : mc_from_bus;
        if (mc_mio_en && mc_rw && mc_ready) mem[mar] = mdr;
        acc_cnt <= mc_mio_en ? acc_cnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          delay;   // -1: ready never rises
        int          exp_lat;
        logic [15:0] exp_rdata;
        bit          exp_to;
    } vec_t;

    vec_t vt[$];

    task automatic run_vec(input vec_t v, input int idx);
        bit got = 0;
        int nmar = 0, nmio = 0, nrw = 0, mar_k = -1;
        @(negedge clk);
        stuck     = (v.delay < 0);
        cur_delay = (v.delay < 0) ? 0 : v.delay;
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            f_req = 1; f_addr = v.addr;
        end
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk); #1;
            if (mc_ld_mar) begin nmar++; mar_k = k; end
            if (mc_mio_en) nmio++;
            if (mc_rw) nrw++;
            if (f_done || d_done) begin
                got = 1;
                chk($sformatf("vec%0d_port", idx), {f_done, d_done}, v.is_d ? 2'b01 : 2'b10);
                chk($sformatf("vec%0d_lat", idx), k, v.exp_lat);
                chk($sformatf("vec%0d_to", idx), timeout_err, v.exp_to);
                if (!v.we)
                    chk($sformatf("vec%0d_rdata", idx), v.is_d ? d_rdata : f_rdata, v.exp_rdata);
                f_req = 0; d_req = 0;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL vec%0d_done_wait actual=none required=done", idx);
            f_req = 0; d_req = 0;
        end
        chk($sformatf("vec%0d_ldmar_cycle", idx), mar_k, 1);
        chk($sformatf("vec%0d_ldmar_count", idx), nmar, 1);
        chk($sformatf("vec%0d_mio_cycles", idx), nmio, v.exp_lat - 2 - int'(v.we));
        chk($sformatf("vec%0d_rw_cycles", idx), nrw, v.we ? v.exp_lat - 3 : 0);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_idle_after", idx), busy, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    initial begin
        int          ord[$];
        int          tdone[$];
        int          model_last;
        bit          pend[2];
        bit          pwe[2];
        logic [15:0] paddr[2], pwd[2];
        int          pdel[2];
        int          exp_port, dec_cyc, exp_lat;
        logic [15:0] ref_mem [logic [15:0]];
        bit          seen;

        rst = 1; f_req = 0; d_req = 0; d_we = 0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        mem[16'h3000] = 16'h1234;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", {f_done, d_done, timeout_err}, 0);
        chk("rst_mc", {mc_ld_mar, mc_ld_mdr, mc_mio_en, mc_rw, mc_from_bus}, 0);
        chk("rst_rdata", {f_rdata, d_rdata}, 0);
        @(negedge clk); rst = 0;

        //           is_d we addr      wdata     dly lat rdata     to
        vt.push_back('{0, 0, 16'h3000, 16'h0000, 0,  3,  16'h1234, 0});
        vt.push_back('{1, 1, 16'h4000, 16'hBEEF, 0,  4,  16'h0000, 0});
        vt.push_back('{1, 0, 16'h4000, 16'h0000, 0,  3,  16'hBEEF, 0});
        vt.push_back('{0, 0, 16'h4000, 16'h0000, 5,  8,  16'hBEEF, 0});
        vt.push_back('{1, 0, 16'h3000, 16'h0000, -1, 18, 16'h0000, 1});
        vt.push_back('{1, 1, 16'h5000, 16'hA5A5, 2,  6,  16'h0000, 0});
        vt.push_back('{1, 0, 16'h5000, 16'h0000, 1,  4,  16'hA5A5, 0});
        vt.push_back('{1, 1, 16'h6000, 16'h1357, -1, 19, 16'h0000, 1});
        vt.push_back('{1, 0, 16'h6000, 16'h0000, 0,  3,  16'h0000, 0});
        foreach (vt[i]) run_vec(vt[i], i);

        // tie from reset: fetch first, then strict alternation every 4 cycles
        pulse_reset();
        stuck = 0; cur_delay = 0;
        f_req = 1; f_addr = 16'h3000;
        d_req = 1; d_we = 0; d_addr = 16'h4000;
        for (int k = 1; k <= 40 && ord.size() < 4; k++) begin
            @(posedge clk); #1;
            if (f_done) begin ord.push_back(0); tdone.push_back(k); end
            if (d_done) begin ord.push_back(1); tdone.push_back(k); end
        end
        f_req = 0; d_req = 0;
        chk("tie_count", ord.size(), 4);
        for (int i = 0; i < ord.size(); i++) begin
            chk($sformatf("tie_order%0d", i), ord[i], i % 2);
            chk($sformatf("tie_time%0d", i), tdone[i], 3 + 4 * i);
        end

        // reset while a write sits in ACCESS
        @(negedge clk);
        stuck = 1;
        d_req = 1; d_we = 1; d_addr = 16'h7000; d_wdata = 16'h2468;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            seen = mc_mio_en;
        end
        chk("rstmid_reached_access", seen, 1);
        #2 rst = 1; d_req = 0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_mc", {mc_ld_mar, mc_ld_mdr, mc_mio_en, mc_rw, mc_from_bus}, 0);
        chk("rstmid_done", {f_done, d_done, timeout_err}, 0);
        chk("rstmid_rdata", {f_rdata, d_rdata}, 0);
        @(negedge clk); rst = 0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (f_done || d_done || busy) seen = 1;
        end
        chk("rstmid_quiet", seen, 0);
        run_vec('{1, 1, 16'h7000, 16'h2468, 0, 4, 16'h0000, 0}, 100);
        run_vec('{1, 0, 16'h7000, 16'h0000, 0, 3, 16'h2468, 0}, 101);

        // randomized traffic against a transaction-level model
        pulse_reset();
        stuck = 0;
        model_last = 1;
        pend[0] = 0; pend[1] = 0;
        exp_port = -1; dec_cyc = 0; exp_lat = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            chk("rnd_excl", mc_ld_mar & mc_ld_mdr, 0);
            if (mc_mio_en && !busy) chk("rnd_mio_busy", 0, 1);
            if (f_done || d_done) begin
                int p;
                p = d_done ? 1 : 0;
                chk("rnd_both_done", f_done & d_done, 0);
                chk("rnd_port", p, exp_port);
                chk("rnd_lat", cyc - dec_cyc, exp_lat);
                chk("rnd_to", timeout_err, 0);
                if (!pwe[p])
                    chk("rnd_rdata", p ? d_rdata : f_rdata,
                        ref_mem.exists(paddr[p]) ? ref_mem[paddr[p]] : 16'h0);
                else
                    ref_mem[paddr[p]] = pwd[p];
                pend[p] = 0;
                model_last = p;
                exp_port = -1;
                if (p == 1) d_req = 0; else f_req = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pend[p]  = 1;
                    pwe[p]   = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    paddr[p] = 16'h8000 + 16'($urandom_range(0, 7));
                    pwd[p]   = 16'($urandom);
                    pdel[p]  = $urandom_range(0, 4);
                    if (p == 1) begin
                        d_req = 1; d_we = pwe[p]; d_addr = paddr[p]; d_wdata = pwd[p];
                    end else begin
                        f_req = 1; f_addr = paddr[p];
                    end
                end
            end
            if (!busy && (pend[0] || pend[1])) begin
                int g;
                if (pend[0] && pend[1]) g = (model_last == 1) ? 0 : 1;
                else                    g = pend[1] ? 1 : 0;
                exp_port  = g;
                dec_cyc   = cyc;
                exp_lat   = 3 + int'(pwe[g]) + pdel[g];
                cur_delay = pdel[g];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
